// File: rtl/opl2_host_if.sv
// OPL2 host port: CPU address/data writes -> opl2_reg_wr stream, timers 1/2, status and IRQ.
// Optional write-busy throttling is enabled with `define OPL2_HOST_IF_BUSY_EN.
module opl2_host_if #(
    parameter int unsigned BUSY_ADDR_CYCLES = 12,
    parameter int unsigned BUSY_DATA_CYCLES = 84,
    parameter int unsigned T1_PRESCALE      = 4,
    parameter int unsigned T2_PRESCALE      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_clk_en,
    input  logic        cpu_cs,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic        cpu_a0,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        irq_n,
    output logic        busy,
    output logic [16:0] opl2_reg_wr
);
    localparam int unsigned P1W = (T1_PRESCALE > 1) ? $clog2(T1_PRESCALE) : 1;
    localparam int unsigned P2W = (T2_PRESCALE > 1) ? $clog2(T2_PRESCALE) : 1;

    logic           wr_d, rd_d;
    logic           wr_ev, rd_ev, wr_acc;
    logic [7:0]     addr_latch;
    logic [7:0]     t1_preset, t2_preset, cnt1, cnt2;
    logic           st1, st2, mask1, mask2, flag1, flag2;
    logic [P1W-1:0] p1;
    logic [P2W-1:0] p2;
    logic           tick1, tick2;
    logic [7:0]     status;

    assign wr_ev  = cpu_cs & cpu_wr & ~wr_d;
    assign rd_ev  = cpu_cs & cpu_rd & ~rd_d;
    assign tick1  = sample_clk_en && (p1 == P1W'(T1_PRESCALE - 1));
    assign tick2  = sample_clk_en && (p2 == P2W'(T2_PRESCALE - 1));
    assign status = {flag1 | flag2, flag1, flag2, 5'b0};

`ifdef OPL2_HOST_IF_BUSY_EN
    localparam int unsigned BMAX = (BUSY_DATA_CYCLES > BUSY_ADDR_CYCLES) ? BUSY_DATA_CYCLES : BUSY_ADDR_CYCLES;
    localparam int unsigned BW   = $clog2(BMAX + 1);

    logic [BW-1:0] busy_cnt;

    assign busy   = (busy_cnt != '0);
    assign wr_acc = wr_ev & ~busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_cnt <= '0;
        end else if (wr_acc) begin
            busy_cnt <= cpu_a0 ? BW'(BUSY_DATA_CYCLES) : BW'(BUSY_ADDR_CYCLES);
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - 1'b1;
        end
    end
`else
    assign busy   = 1'b0;
    assign wr_acc = wr_ev;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_d        <= 1'b0;
            rd_d        <= 1'b0;
            cpu_dout    <= '0;
            irq_n       <= 1'b1;
            opl2_reg_wr <= '0;
            addr_latch  <= '0;
            t1_preset   <= '0;
            t2_preset   <= '0;
            cnt1        <= '0;
            cnt2        <= '0;
            st1         <= 1'b0;
            st2         <= 1'b0;
            mask1       <= 1'b0;
            mask2       <= 1'b0;
            flag1       <= 1'b0;
            flag2       <= 1'b0;
            p1          <= '0;
            p2          <= '0;
        end else begin
            wr_d        <= cpu_cs & cpu_wr;
            rd_d        <= cpu_cs & cpu_rd;
            opl2_reg_wr <= '0;
            irq_n       <= ~(flag1 | flag2);

            // Status is sampled before this edge's flag updates (pre-set value).
            if (rd_ev)
                cpu_dout <= cpu_a0 ? 8'hFF : status;

            if (sample_clk_en) begin
                p1 <= tick1 ? '0 : p1 + 1'b1;
                p2 <= tick2 ? '0 : p2 + 1'b1;
            end

            if (st1 && tick1) begin
                if (cnt1 == 8'hFF) begin
                    cnt1 <= t1_preset;
                    if (!mask1) flag1 <= 1'b1;
                end else begin
                    cnt1 <= cnt1 + 8'd1;
                end
            end

            if (st2 && tick2) begin
                if (cnt2 == 8'hFF) begin
                    cnt2 <= t2_preset;
                    if (!mask2) flag2 <= 1'b1;
                end else begin
                    cnt2 <= cnt2 + 8'd1;
                end
            end

            // Placed after the timer updates so a clear or start load wins over a same-edge tick.
            if (wr_acc) begin
                if (!cpu_a0) begin
                    addr_latch <= cpu_din;
                end else begin
                    opl2_reg_wr <= {1'b1, addr_latch, cpu_din};
                    case (addr_latch)
                        8'h02: t1_preset <= cpu_din;
                        8'h03: t2_preset <= cpu_din;
                        8'h04: begin
                            if (cpu_din[7]) begin
                                flag1 <= 1'b0;
                                flag2 <= 1'b0;
                            end else begin
                                mask1 <= cpu_din[6];
                                mask2 <= cpu_din[5];
                                st2   <= cpu_din[1];
                                st1   <= cpu_din[0];
                                if (cpu_din[0] && !st1) cnt1 <= t1_preset;
                                if (cpu_din[1] && !st2) cnt2 <= t2_preset;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/opl2_host_if.md
Name: opl2_host_if

Overview:
Host-side front end that produces the opl2_reg_wr stream consumed by the operator/channel control logic. It converts CPU port accesses (address port A0=0, data port A0=1) into single-cycle register-write transactions. It implements the OPL2 timer block (registers 02h/03h/04h), the status register readback and the IRQ output. Sits between the system bus glue and all opl2_reg_wr consumers.

Parameters:
BUSY_ADDR_CYCLES, 12, clk cycles the port stays busy after an address write
BUSY_DATA_CYCLES, 84, clk cycles the port stays busy after a data write
T1_PRESCALE, 4, sample_clk_en pulses per timer-1 tick (~80 us)
T2_PRESCALE, 16, sample_clk_en pulses per timer-2 tick (~320 us)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
sample_clk_en  input  1  one-cycle pulse per output sample (~49.7 kHz)
cpu_cs  input  1  chip select
cpu_wr  input  1  write strobe, level; qualified with cpu_cs
cpu_rd  input  1  read strobe, level; qualified with cpu_cs
cpu_a0  input  1  0 = address/status port, 1 = data port
cpu_din  input  8  write data
cpu_dout  output  8  read data, registered
irq_n  output  1  active-low interrupt, registered
busy  output  1  write port busy
opl2_reg_wr  output  opl2_reg_wr_t  {valid, address[7:0], data[7:0]}, registered

Behaviour:
- Reset (async, reset_n=0): cpu_dout=0, irq_n=1, busy=0, opl2_reg_wr all 0, address latch=0, T1/T2 presets=0, counters=0, start/mask bits=0, flags=0, prescalers=0, edge-detect registers=0.
- Access events are edge-detected. A write event is the rising edge of (cpu_cs&cpu_wr). A read event is the rising edge of (cpu_cs&cpu_rd). A strobe held N cycles counts as one event.
- Address write (a0=0): address latch <= cpu_din. No opl2_reg_wr.valid.
- Data write (a0=1): the next cycle drives opl2_reg_wr.valid=1 for exactly 1 cycle, with address=latch and data=cpu_din. Latency is 1 clk from the event cycle. The address latch is unchanged, so repeated data writes reuse it.
- Every data write is forwarded, including 02h/03h/04h. Downstream blocks ignore addresses they do not own.
- Timer registers, updated in the same cycle that valid is asserted:
  - 02h: T1 preset.
  - 03h: T2 preset.
  - 04h with bit7=1: clear both flags; all other bits ignored.
  - 04h with bit7=0: mask1=bit6, mask2=bit5, st2=bit1, st1=bit0.
- Prescalers: free-running counters 0..T1_PRESCALE-1 and 0..T2_PRESCALE-1, advanced on sample_clk_en. A tick is issued on wrap.
- Timer counters:
  - A 0->1 transition of stN loads counter<=preset.
  - While stN=1, each tick increments the counter.
  - On a tick at FFh: counter reloads the preset; flagN<=1 unless maskN.
  - stN=0: counter holds its value; no flag is set.
  - A preset change while running takes effect at the next reload.
- Status byte = {flag1|flag2, flag1, flag2, 5'b0}. irq_n = !(flag1|flag2), registered (1 clk after the flag).
- Read event: the next cycle cpu_dout <= status when a0=0, FFh when a0=1. cpu_dout holds until the next read event.
- Simultaneous events:
  - A 04h bit7 clear in the same cycle as an overflow: clear wins, and the flag stays 0.
  - A read in the same cycle as a flag set returns the pre-set status.
  - A read and a write event in the same cycle are both serviced.
- Flags are sticky until cleared via 04h bit7. The mask bits do not clear existing flags.
- reset_n asserted mid-access: everything returns to reset values immediately. Any in-flight valid is dropped.

Optional Feature:
OPL2_HOST_IF_BUSY_EN
- Defined:
  - An accepted address write loads the busy counter with BUSY_ADDR_CYCLES; an accepted data write loads it with BUSY_DATA_CYCLES.
  - busy=1 while the counter is nonzero; the counter decrements each clk.
  - Write events while busy=1 are discarded: no latch update, no valid, no timer update.
  - Reads are never blocked.
- Not defined: busy is tied 0, there is no counter, and every write event is accepted.

Test Plan:
- Write addr A0h, then data 44h -> one opl2_reg_wr pulse {A0h,44h} 1 clk after the data event. Holding cpu_wr for 5 cycles still yields a single pulse.
- Write 02h=FEh, then 04h=01h, then apply 8 sample_clk_en pulses -> flag1 sets on the 2nd T1 tick. Status reads C0h and irq_n=0. Writing 04h=80h then gives status 00h and irq_n=1.
- Write 03h=FFh, then 04h=22h (T2 masked, started), then apply 16 sample_clk_en pulses -> the counter reloads, status stays 00h and irq_n stays 1.
- With BUSY_EN defined: write an address, then a data event 5 clks later -> the data event is dropped and no valid pulse appears. After 12 clks, a retry is accepted and busy stays high 84 clks.
- Start T1 with preset FFh, then write 04h=80h on the same cycle as the overflow tick -> flag1 remains 0 and irq_n remains 1.
- Assert reset_n=0 during a data event -> valid never pulses, and all outputs match reset values within the reset cycle.
